// File: rtl/alu_ex_if.sv
// Handshake bundle between the decode/issue side, the execute stage and the
// memory stage. The perf counter signals exist only when ALU_PERF_CNT_EN is
// defined.
interface alu_ex_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_op;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [REG_AW-1:0] rd_in;
    logic              reg_write_in;
    logic [XLEN-1:0]   branch_target_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   alu_result;
    logic              zero;
    logic [REG_AW-1:0] rd_out;
    logic              reg_write_out;
    logic              branch_taken;
    logic [XLEN-1:0]   branch_target;
`ifdef ALU_PERF_CNT_EN
    logic [31:0]       perf_retired;
    logic [31:0]       perf_br_taken;
`endif

    // Upstream/downstream environment view.
    modport master (
        output in_valid, alu_op, op_a, op_b, rd_in, reg_write_in,
               branch_target_in, flush, out_ready,
        input  in_ready, out_valid, alu_result, zero, rd_out,
               reg_write_out, branch_taken, branch_target
`ifdef ALU_PERF_CNT_EN
        , input perf_retired, perf_br_taken
`endif
    );

    // Execute stage view.
    modport slave (
        input  in_valid, alu_op, op_a, op_b, rd_in, reg_write_in,
               branch_target_in, flush, out_ready,
        output in_ready, out_valid, alu_result, zero, rd_out,
               reg_write_out, branch_taken, branch_target
`ifdef ALU_PERF_CNT_EN
        , output perf_retired, perf_br_taken
`endif
    );
endinterface

// File: rtl/alu_execute_stage.sv
// Execute stage: ALU (arith/logic/shift/compare) plus branch decision,
// registered into an EX/MEM slot with valid/ready back-pressure and flush.
// Optional feature macro: ALU_PERF_CNT_EN adds retired / taken-branch
// transfer counters on the interface.
module alu_execute_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic     clk,
    input  logic     rst,
    alu_ex_if.slave  bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BGE  = 4'b1101;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

    // Every opcode from BEQ upward is a branch compare.
    function automatic logic is_branch(input logic [3:0] op);
        return (op >= OP_BEQ);
    endfunction

    // Branch condition from the three primitive compares.
    function automatic logic branch_cond(input logic [3:0] op,
                                         input logic       eq,
                                         input logic       lt_s,
                                         input logic       lt_u);
        logic c;
        c = 1'b0;
        case (op)
            OP_BEQ:  c = eq;
            OP_BNE:  c = !eq;
            OP_BLT:  c = lt_s;
            OP_BGE:  c = !lt_s;
            OP_BLTU: c = lt_u;
            OP_BGEU: c = !lt_u;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic signed [XLEN-1:0] sra_v;
    logic [4:0]             shamt;
    logic                   eq;
    logic                   lt_s;
    logic                   lt_u;
    logic                   br_op;
    logic                   cond;
    logic [XLEN-1:0]        result;

    assign a_s   = bus.op_a;
    assign b_s   = bus.op_b;
    assign shamt = bus.op_b[4:0];
    assign sra_v = a_s >>> shamt;
    assign eq    = (bus.op_a == bus.op_b);
    assign lt_s  = (a_s < b_s);
    assign lt_u  = (bus.op_a < bus.op_b);
    assign br_op = is_branch(bus.alu_op);
    assign cond  = branch_cond(bus.alu_op, eq, lt_s, lt_u);

    // ALU result for the incoming instruction.
    always_comb begin
        result = '0;
        case (bus.alu_op)
            OP_ADD:  result = bus.op_a + bus.op_b;
            OP_SUB:  result = bus.op_a - bus.op_b;
            OP_AND:  result = bus.op_a & bus.op_b;
            OP_OR:   result = bus.op_a | bus.op_b;
            OP_XOR:  result = bus.op_a ^ bus.op_b;
            OP_SLL:  result = bus.op_a << shamt;
            OP_SRL:  result = bus.op_a >> shamt;
            OP_SRA:  result = sra_v;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            default: result = {{(XLEN-1){1'b0}}, cond};
        endcase
    end

    // EX/MEM register state.
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    logic              zero_q, zero_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              br_taken_q, br_taken_d;
    logic [XLEN-1:0]   br_target_q, br_target_d;
    logic              in_ready;
    logic              capture;
    logic              transfer;

    // Accept whenever the slot is empty or being drained this cycle.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign capture  = bus.in_valid && in_ready && !bus.flush;
    assign transfer = out_valid_q && bus.out_ready && !bus.flush;

    // Next-state: flush beats capture, capture beats drain, else hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        alu_result_d = alu_result_q;
        zero_d       = zero_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        br_taken_d   = br_taken_q;
        br_target_d  = br_target_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
            br_taken_d  = 1'b0;
        end else if (capture) begin
            out_valid_d  = 1'b1;
            alu_result_d = result;
            zero_d       = (result == '0);
            rd_d         = bus.rd_in;
            reg_write_d  = bus.reg_write_in && !br_op;
            br_taken_d   = br_op && cond;
            br_target_d  = bus.branch_target_in;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // EX/MEM register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            zero_q       <= 1'b0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.alu_result    = alu_result_q;
    assign bus.zero          = zero_q;
    assign bus.rd_out        = rd_q;
    assign bus.reg_write_out = reg_write_q;
    assign bus.branch_taken  = br_taken_q;
    assign bus.branch_target = br_target_q;

`ifdef ALU_PERF_CNT_EN
    logic [31:0] perf_ret_q, perf_ret_d;
    logic [31:0] perf_br_q, perf_br_d;

    // Counters advance only on real (non-squashed) transfers; wrap naturally.
    always_comb begin
        perf_ret_d = perf_ret_q;
        perf_br_d  = perf_br_q;
        if (transfer) begin
            perf_ret_d = perf_ret_q + 32'd1;
            if (br_taken_q) perf_br_d = perf_br_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ret_q <= '0;
            perf_br_q  <= '0;
        end else begin
            perf_ret_q <= perf_ret_d;
            perf_br_q  <= perf_br_d;
        end
    end

    assign bus.perf_retired  = perf_ret_q;
    assign bus.perf_br_taken = perf_br_q;
`else
    logic unused_transfer;
    assign unused_transfer = transfer;
`endif
endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: the driver pushes the expected
// EX/MEM contents when an instruction is accepted; a negedge monitor pops
// and compares on every transfer and drops entries squashed by flush.
module tb_alu_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ex_if #(.XLEN(32), .REG_AW(5)) bus();

    alu_execute_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
        logic        rw;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic [31:0] tgt;
    } exp_t;

    vec_t vecs[17];
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Hand-computed vectors: op, a, b, result, branch_taken, reg_write_out.
    task automatic init_vecs();
        vecs[0]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
        vecs[1]  = '{4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1};
        vecs[2]  = '{4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b1};
        vecs[3]  = '{4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b1};
        vecs[4]  = '{4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b1};
        vecs[5]  = '{4'b0101, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1'b1};
        vecs[6]  = '{4'b0110, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b1};
        vecs[7]  = '{4'b0111, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b1};
        vecs[8]  = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1};
        vecs[9]  = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
        vecs[10] = '{4'b1010, 32'h12345678, 32'h12345678, 32'h00000001, 1'b1, 1'b0};
        vecs[11] = '{4'b1011, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0};
        vecs[12] = '{4'b1100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0};
        vecs[13] = '{4'b1101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        vecs[14] = '{4'b1110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        vecs[15] = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0};
        vecs[16] = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    endtask

    task automatic drive_vec(input int idx);
        bus.alu_op           = vecs[idx].op;
        bus.op_a             = vecs[idx].a;
        bus.op_b             = vecs[idx].b;
        bus.rd_in            = 5'(idx + 1);
        bus.reg_write_in     = 1'b1;
        bus.branch_target_in = 32'h1000 + 32'(idx * 4);
    endtask

    // Present vector idx until accepted (bounded), pushing its expectation.
    task automatic issue(input int idx);
        exp_t e;
        bit   accepted;
        accepted = 1'b0;
        drive_vec(idx);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            if (bus.in_ready && !bus.flush) begin
                accepted = 1'b1;
                e.res  = vecs[idx].res;
                e.zero = (vecs[idx].res == 32'h0);
                e.rd   = 5'(idx + 1);
                e.rw   = vecs[idx].rw;
                e.br   = vecs[idx].br;
                e.tgt  = 32'h1000 + 32'(idx * 4);
                q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compare on transfer, check hold while stalled, drop on flush.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else if (bus.flush) begin
                void'(q.pop_front());
            end else if (bus.out_ready) begin
                exp_t e;
                e = q.pop_front();
                chk("alu_result",    bus.alu_result,    e.res);
                chk("zero",          32'(bus.zero),     32'(e.zero));
                chk("rd_out",        32'(bus.rd_out),   32'(e.rd));
                chk("reg_write_out", 32'(bus.reg_write_out), 32'(e.rw));
                chk("branch_taken",  32'(bus.branch_taken),  32'(e.br));
                chk("branch_target", bus.branch_target, e.tgt);
            end else begin
                chk("stall_hold_result", bus.alu_result, q[0].res);
                chk("stall_hold_rd",     32'(bus.rd_out), 32'(q[0].rd));
            end
        end
    end

    initial begin
        init_vecs();
        bus.in_valid         = 1'b0;
        bus.alu_op           = 4'd0;
        bus.op_a             = 32'd0;
        bus.op_b             = 32'd0;
        bus.rd_in            = 5'd0;
        bus.reg_write_in     = 1'b0;
        bus.branch_target_in = 32'd0;
        bus.flush            = 1'b0;
        bus.out_ready        = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid",     32'(bus.out_valid),     32'd0);
        chk("rst_branch_taken",  32'(bus.branch_taken),  32'd0);
        chk("rst_reg_write_out", 32'(bus.reg_write_out), 32'd0);
        chk("rst_alu_result",    bus.alu_result,         32'd0);
        chk("rst_branch_target", bus.branch_target,      32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming all opcodes back to back
        for (int i = 0; i < 17; i++) issue(i);
        repeat (3) @(posedge clk);
        #1;
`ifdef ALU_PERF_CNT_EN
        chk("perf_retired_stream",  bus.perf_retired,  32'd17);
        chk("perf_br_taken_stream", bus.perf_br_taken, 32'd3);
`endif

        // Stall for three cycles, then release with no bubble
        bus.out_ready = 1'b0;
        issue(6);
        fork
            issue(7);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
                    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        @(negedge clk);
        chk("no_bubble_out_valid", 32'(bus.out_valid), 32'd1);
        chk("no_bubble_result",    bus.alu_result,     32'hF8000000);
        @(posedge clk);
        #1;
        chk("drained_out_valid", 32'(bus.out_valid), 32'd0);

        // Flush a held result together with a same-cycle input
        bus.out_ready = 1'b0;
        issue(16);
        @(posedge clk);
        #1;
        drive_vec(0);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid",     32'(bus.out_valid),     32'd0);
        chk("flush_reg_write_out", 32'(bus.reg_write_out), 32'd0);
        chk("flush_branch_taken",  32'(bus.branch_taken),  32'd0);
        @(posedge clk);
        #1;
        chk("flush_input_dropped", 32'(bus.out_valid), 32'd0);
`ifdef ALU_PERF_CNT_EN
        chk("perf_retired_flush",  bus.perf_retired,  32'd19);
        chk("perf_br_taken_flush", bus.perf_br_taken, 32'd3);
`endif
        chk("queue_empty_flush", 32'(q.size()), 32'd0);

        // Reset pulse while a taken branch is stalled in the slot
        issue(12);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        q.delete();
        chk("rst_stall_out_valid",    32'(bus.out_valid),    32'd0);
        chk("rst_stall_branch_taken", 32'(bus.branch_taken), 32'd0);
        chk("rst_stall_alu_result",   bus.alu_result,        32'd0);
`ifdef ALU_PERF_CNT_EN
        chk("rst_perf_retired",  bus.perf_retired,  32'd0);
        chk("rst_perf_br_taken", bus.perf_br_taken, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;

        // Post-reset operation resumes
        issue(9);
        issue(15);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty_end", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
